rr_mux_arbiter: RTL and testbench

//  4:1 round-robin arbitrating multiplexer. It is the gather-side counterpart of the team's 1:4 select decoder.

---
 rtl/rr_mux_arbiter.sv | 107 ++++++++++
 tb/tb_rr_mux_arbiter.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/rr_mux_arbiter.sv
// 4:1 round-robin arbitrating mux: grants one requester and registers its data plus 2-bit source code.
// Latency: one cycle from input handshake edge to out_valid/out_data/out_sel.
// Backpressure: out_ready=0 with a held transfer stalls the register; in_ready stays 0 until it drains.
module rr_mux_arbiter #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [3:0]          in_valid,
  input  logic [4*DATA_W-1:0] in_data,
  output logic [3:0]          in_ready,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_data,
  output logic [1:0]          out_sel,
  output logic [CNT_W-1:0]    xfer_cnt
);

  // The output register's occupancy is the only FSM state.
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        last_grant_q, last_grant_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [1:0]        sel_q, sel_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic       load_en;
  logic       xfer;
  logic       any_vld;
  logic [1:0] grant;
  logic [1:0] cand;

  assign load_en = (state_q == EMPTY) | out_ready;
  assign xfer    = (state_q == FULL) & out_ready;

  // Round-robin search starting after the last grant; scanning farthest-first lets the nearest valid win.
  always_comb begin
    grant   = last_grant_q;
    any_vld = 1'b0;
    cand    = last_grant_q;
    for (int k = 4; k >= 1; k--) begin
      cand = last_grant_q + 2'(k);
      if (in_valid[cand]) begin
        grant   = cand;
        any_vld = 1'b1;
      end
    end
  end

  // Accept strobe: one-hot on the winner only when the register can take data and not in reset.
  always_comb begin
    in_ready = 4'b0000;
    if (rst_n && load_en && any_vld) begin
      in_ready = 4'b0001 << grant;
    end
  end

  // Next-state: count completed output transfers, load the winner whenever the register frees up.
  always_comb begin
    state_d      = state_q;
    data_d       = data_q;
    sel_d        = sel_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    if (xfer) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    if (load_en) begin
      if (any_vld) begin
        state_d      = FULL;
        data_d       = in_data[32'(grant)*DATA_W +: DATA_W];
        sel_d        = grant;
        last_grant_d = grant;
      end else begin
        state_d = EMPTY;
      end
    end
  end

  // State registers with synchronous reset; channel 0 wins first after reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= EMPTY;
      data_q       <= '0;
      sel_q        <= 2'b00;
      last_grant_q <= 2'd3;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      data_q       <= data_d;
      sel_q        <= sel_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
    end
  end

  assign out_valid = (state_q == FULL);
  assign out_data  = data_q;
  assign out_sel   = sel_q;
  assign xfer_cnt  = cnt_q;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Bench for rr_mux_arbiter: table vectors, directed corner sequences and random traffic vs a reference model.
// A second instance with a 4-bit counter shares the inputs to exercise counter wrap.
module tb_rr_mux_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  in_valid;
  logic [31:0] in_data;
  logic        out_ready;

  logic [3:0]  in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [1:0]  out_sel;
  logic [15:0] xfer_cnt;

  logic [3:0]  ir_s;
  logic        ov_s;
  logic [7:0]  od_s;
  logic [1:0]  os_s;
  logic [3:0]  cnt_s;

  int checks   = 0;
  int failures = 0;
  bit check_en = 1'b0;

  // reference model state
  int       m_lg;
  bit       m_vld;
  logic [7:0] m_data;
  int       m_sel;
  int       m_cnt;

  typedef struct {
    logic [3:0]  iv;
    logic        ordy;
    logic [31:0] dat;
    logic [3:0]  ir;
    logic        vld;
    logic [1:0]  sel;
    logic [7:0]  od;
    logic [15:0] cnt;
  } vec_t;

  vec_t tbl[20];

  always #5 clk = ~clk;

  rr_mux_arbiter #(.DATA_W(8), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sel(out_sel),
    .xfer_cnt(xfer_cnt)
  );

  rr_mux_arbiter #(.DATA_W(8), .CNT_W(4)) dut_s (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_ready(ir_s),
    .out_valid(ov_s), .out_ready(out_ready), .out_data(od_s), .out_sel(os_s),
    .xfer_cnt(cnt_s)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Winner by the round-robin rule: first valid channel after the last grant, or -1.
  function automatic int m_grant(input logic [3:0] v);
    for (int k = 1; k <= 4; k++) begin
      if (v[(m_lg + k) % 4]) return (m_lg + k) % 4;
    end
    return -1;
  endfunction

  function automatic logic [3:0] m_ir();
    int g;
    if (!rst_n) return 4'b0000;
    if (m_vld && !out_ready) return 4'b0000;
    g = m_grant(in_valid);
    if (g < 0) return 4'b0000;
    return 4'(1 << g);
  endfunction

  task automatic tick();
    int g;
    @(negedge clk);
    if (check_en) begin
      chk("m_in_ready", 32'(in_ready), 32'(m_ir()));
      chk("m_out_valid", 32'(out_valid), 32'(m_vld));
      chk("m_out_data", 32'(out_data), 32'(m_data));
      chk("m_out_sel", 32'(out_sel), 32'(m_sel));
      chk("m_cnt16", 32'(xfer_cnt), 32'(m_cnt % 65536));
      chk("m_cnt4", 32'(cnt_s), 32'(m_cnt % 16));
      chk("m_in_ready4", 32'(ir_s), 32'(m_ir()));
    end
    @(posedge clk);
    if (!rst_n) begin
      m_vld = 1'b0; m_data = 8'h00; m_sel = 0; m_cnt = 0; m_lg = 3;
    end else begin
      if (m_vld && out_ready) m_cnt++;
      if (!m_vld || out_ready) begin
        g = m_grant(in_valid);
        if (g >= 0) begin
          m_vld  = 1'b1;
          m_data = in_data[g*8 +: 8];
          m_sel  = g;
          m_lg   = g;
        end else begin
          m_vld = 1'b0;
        end
      end
    end
    #1;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      tbl[i] = '{4'hF, 1'b1, 32'hA3A2A1A0, 4'(1 << (i % 4)), 1'b1, 2'(i % 4), 8'hA0 + 8'(i % 4), 16'(i)};
    end
    tbl[8]  = '{4'h0, 1'b1, 32'hA3A2A1A0, 4'h0, 1'b0, 2'd3, 8'hA3, 16'd8};
    tbl[9]  = '{4'h4, 1'b0, 32'hA35CA1A0, 4'h4, 1'b1, 2'd2, 8'h5C, 16'd8};
    for (int i = 10; i < 14; i++) begin
      tbl[i] = '{4'h4, 1'b0, 32'hA35CA1A0, 4'h0, 1'b1, 2'd2, 8'h5C, 16'd8};
    end
    tbl[14] = '{4'h0, 1'b1, 32'hA35CA1A0, 4'h0, 1'b0, 2'd2, 8'h5C, 16'd9};
    tbl[15] = '{4'h8, 1'b1, 32'hA3A2A1A0, 4'h8, 1'b1, 2'd3, 8'hA3, 16'd9};
    tbl[16] = '{4'h2, 1'b1, 32'hA3A2A1A0, 4'h2, 1'b1, 2'd1, 8'hA1, 16'd10};
    tbl[17] = '{4'h3, 1'b1, 32'hA3A2A1A0, 4'h1, 1'b1, 2'd0, 8'hA0, 16'd11};
    tbl[18] = '{4'h3, 1'b1, 32'hA3A2A1A0, 4'h2, 1'b1, 2'd1, 8'hA1, 16'd12};
    tbl[19] = '{4'h0, 1'b1, 32'hA3A2A1A0, 4'h0, 1'b0, 2'd1, 8'hA1, 16'd13};

    // reset held 3 cycles with all requests asserted
    rst_n = 1'b0; in_valid = 4'hF; in_data = 32'hA3A2A1A0; out_ready = 1'b1;
    m_lg = 3; m_vld = 1'b0; m_data = 8'h00; m_sel = 0; m_cnt = 0;
    tick();
    check_en = 1'b1;
    tick();
    tick();
    chk("rst_in_ready", 32'(in_ready), 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_sel", 32'(out_sel), 32'h0);
    chk("rst_xfer_cnt", 32'(xfer_cnt), 32'h0);
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready", 32'(in_ready), 32'h1);
    tick();
    chk("rel_out_valid", 32'(out_valid), 32'h1);
    chk("rel_out_sel", 32'(out_sel), 32'h0);
    chk("rel_out_data", 32'(out_data), 32'hA0);

    // table: fairness, drain, backpressure, sparse requests
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_valid = tbl[i].iv; out_ready = tbl[i].ordy; in_data = tbl[i].dat;
      #1;
      chk($sformatf("tbl%0d_in_ready", i), 32'(in_ready), 32'(tbl[i].ir));
      tick();
      chk($sformatf("tbl%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].vld));
      chk($sformatf("tbl%0d_out_sel", i), 32'(out_sel), 32'(tbl[i].sel));
      chk($sformatf("tbl%0d_out_data", i), 32'(out_data), 32'(tbl[i].od));
      chk($sformatf("tbl%0d_xfer_cnt", i), 32'(xfer_cnt), 32'(tbl[i].cnt));
    end

    // counter wrap on the 4-bit instance: 17 transfers
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; in_valid = 4'hF; out_ready = 1'b1; in_data = 32'hA3A2A1A0;
    for (int k = 1; k <= 18; k++) begin
      tick();
      if (k == 16) chk("wrap_cnt_15", 32'(cnt_s), 32'd15);
      if (k == 17) chk("wrap_cnt_0", 32'(cnt_s), 32'd0);
      if (k == 18) begin
        chk("wrap_cnt_1", 32'(cnt_s), 32'd1);
        chk("wrap_cnt16_17", 32'(xfer_cnt), 32'd17);
      end
    end

    // reset while FULL and stalled
    in_valid = 4'h4; out_ready = 1'b0;
    tick();
    tick();
    chk("stall_out_valid", 32'(out_valid), 32'h1);
    rst_n = 1'b0; in_valid = 4'hF; out_ready = 1'b1;
    #1;
    chk("midrst_in_ready", 32'(in_ready), 32'h0);
    tick();
    chk("midrst_out_valid", 32'(out_valid), 32'h0);
    chk("midrst_xfer_cnt", 32'(xfer_cnt), 32'h0);
    rst_n = 1'b1;
    #1;
    chk("midrst_lg3_in_ready", 32'(in_ready), 32'h1);
    tick();

    // random traffic against the model
    for (int n = 0; n < 400; n++) begin
      rst_n     = ($urandom_range(0, 39) != 0);
      in_valid  = 4'($urandom);
      in_data   = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
